score_display_ctrl: RTL and testbench
=====================================

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_COUNT, default 8, number of BCD digits driven to the 7-segment number renderer.
REQ-002 SHALL have parameter BIN_WIDTH, default 27, width of the binary input value, sufficient for 10^8-1.
REQ-003 SHALL have port clock, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port value, input, BIN_WIDTH, the binary number to display.
REQ-006 SHALL have port value_valid, input, 1, qualifies value.
REQ-007 SHALL have port value_ready, output, 1, controller can accept a value.
REQ-008 SHALL have port frame_start, input, 1, single-cycle pulse at the start of the VGA vertical blank.
REQ-009 SHALL have port number, output, DIGIT_COUNT*4, packed BCD with the most significant digit in the top nibble, to the number renderer.
REQ-010 SHALL have port busy, output, 1, high in CONVERT or PENDING.
REQ-011 SHALL have port updated, output, 1, single-cycle pulse when number changes.
REQ-012 SHALL have port overflow, output, 1, the last accepted value was saturated.

Function
REQ-013 SHALL implement three states: IDLE, CONVERT, PENDING.
REQ-014 SHALL drive value_ready high only in IDLE; a handshake occurs on a rising edge with value_valid && value_ready.
REQ-015 SHALL, on handshake, capture value, clear the BCD accumulator, zero the bit counter and enter CONVERT.
REQ-016 SHALL, at handshake, substitute 10^DIGIT_COUNT-1 when value exceeds it, setting overflow to 1; otherwise it SHALL clear overflow.
REQ-017 SHALL hold overflow until the next handshake.
REQ-018 SHALL, in CONVERT, process one bit per cycle MSB-first using shift-and-add-3: each digit >=5 gets +3, then {bcd,bin} shift left by one.
REQ-019 SHALL leave CONVERT for PENDING after exactly BIN_WIDTH CONVERT cycles.
REQ-020 SHALL ignore frame_start while in IDLE or CONVERT.
REQ-021 SHALL, on the first rising edge in PENDING with frame_start=1, load number from the accumulator, pulse updated for one cycle and return to IDLE.
REQ-022 SHALL accept a new value no earlier than the cycle after returning to IDLE; back-to-back values therefore commit on successive frames.
REQ-023 SHALL never change number except at the commit edge of REQ-021, so the renderer never sees a mid-frame or partially converted value.
REQ-024 SHALL keep value_valid without ready a no-op; the value is not latched until the handshake.

Reset
REQ-025 SHALL, on reset assertion, asynchronously force state=IDLE, number=0, updated=0, overflow=0, busy=0 and the counter and accumulator to 0.
REQ-026 SHALL, on reset during CONVERT or PENDING, discard the pending value and leave number at 0.
REQ-027 SHALL drive value_ready=1 on the first edge after reset deassertion.

Structure
REQ-028 SHALL place the state enum and the DIGIT_COUNT/BIN_WIDTH defaults in the shared display package.
REQ-029 SHALL use one sub-module, bcd_add3, as a combinational per-digit adjust, instantiated DIGIT_COUNT times by generate.
REQ-030 SHALL size the counter as $clog2(BIN_WIDTH+1) bits.

Verification
REQ-031 Bench SHALL apply value=12345678 then frame_start 40 cycles later -> number=32'h12345678, updated pulses once, overflow=0.
REQ-032 Bench SHALL apply value=0x5F5E100 (10^8) -> number=32'h99999999, overflow=1.
REQ-033 Bench SHALL pulse frame_start at handshake+10 (CONVERT) and again at +60 -> number=32'h00000042 for value=42, commit at the second pulse only.
REQ-034 Bench SHALL present value_valid=1 with value=7 while in PENDING, then commit -> value_ready=0 until commit; the next handshake is value=7; first commit shows the prior value.
REQ-035 Bench SHALL assert reset at handshake+5 -> number=0, value_ready=1 after deassertion, updated never pulses.
REQ-036 Bench SHALL apply value=0 and value=99999999 -> number=32'h00000000 and 32'h99999999, latency of BIN_WIDTH+1 edges to PENDING in each case.

Source files
------------

// File: rtl/score_display_ctrl_pkg.sv
// Shared definitions for the score display path: controller state encoding,
// default digit/width sizing and the decimal ceiling helper.
package score_display_ctrl_pkg;

  localparam int DEFAULT_DIGIT_COUNT = 8;
  localparam int DEFAULT_BIN_WIDTH   = 27;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  // Largest value representable with the given number of decimal digits.
  function automatic longint unsigned max_decimal(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/score_display_ctrl_bcd_add3.sv
// Per-digit double-dabble correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Conditional add-3 on a single nibble.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: accepts a binary score, converts it to packed BCD
// with a bit-serial shift-and-add-3, and hands the result to the 7-segment
// renderer only at the start of vertical blank so a frame never shows a
// partially updated number.
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int DIGIT_COUNT = DEFAULT_DIGIT_COUNT,
  parameter int BIN_WIDTH   = DEFAULT_BIN_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BIN_WIDTH-1:0]     value,
  input  logic                     value_valid,
  output logic                     value_ready,
  input  logic                     frame_start,
  output logic [DIGIT_COUNT*4-1:0] number,
  output logic                     busy,
  output logic                     updated,
  output logic                     overflow
);

  localparam int                BCD_W    = DIGIT_COUNT * 4;
  localparam int                CNT_W    = $clog2(BIN_WIDTH + 1);
  localparam longint unsigned   MAX_DEC  = max_decimal(DIGIT_COUNT);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BIN_WIDTH - 1);

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic                 shift_en;
  logic                 commit;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     number_q;
  logic                 updated_q;
  logic                 overflow_q;
  logic [BIN_WIDTH:0]   sat_in;

  // Clamp to the largest displayable value; the top bit flags that a clamp happened.
  function automatic logic [BIN_WIDTH:0] saturate(input logic [BIN_WIDTH-1:0] v);
    logic [63:0] wide;
    wide = 64'(v);
    if (wide > MAX_DEC) begin
      return {1'b1, BIN_WIDTH'(MAX_DEC)};
    end
    return {1'b0, v};
  endfunction

  assign sat_in = saturate(value);

  for (genvar g = 0; g < DIGIT_COUNT; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit    (bcd_q[g*4 +: 4]),
      .adjusted (bcd_adj[g*4 +: 4])
    );
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (value_valid) begin
          accept  = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        shift_en = 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit counter, BCD accumulator and overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= sat_in[BIN_WIDTH];
    end else if (shift_en) begin
      cnt_q      <= cnt_q + 1'b1;
      bcd_q      <= BCD_W'({bcd_adj, bin_q[BIN_WIDTH-1]});
    end
  end

  // Binary shift register feeding the accumulator MSB-first; contents are
  // only meaningful after a handshake, so it carries no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      bin_q <= sat_in[BIN_WIDTH-1:0];
    end else if (shift_en) begin
      bin_q <= bin_q << 1;
    end
  end

  // Renderer-facing number changes only at the vertical-blank commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      number_q  <= '0;
      updated_q <= 1'b0;
    end else begin
      updated_q <= commit;
      if (commit) begin
        number_q <= bcd_q;
      end
    end
  end

  assign value_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign number      = number_q;
  assign updated     = updated_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: stimulus pushes the expected
// decimal rendering on each handshake; a monitor pops on every update pulse.
module tb_score_display_ctrl;

  localparam int BIN_WIDTH = 27;
  localparam int DIGITS    = 8;

  typedef struct packed {
    logic [31:0] number;
    logic        ovf;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [BIN_WIDTH-1:0] value;
  logic                 value_valid;
  logic                 value_ready;
  logic                 frame_start;
  logic [DIGITS*4-1:0]  number;
  logic                 busy;
  logic                 updated;
  logic                 overflow;

  int   vectors     = 0;
  int   miscompares = 0;
  int   upd_count   = 0;
  exp_t exp_q[$];
  logic [31:0] last_number = '0;

  score_display_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .frame_start (frame_start),
    .number      (number),
    .busy        (busy),
    .updated     (updated),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: clamp to eight decimal digits, then peel digits with % and /.
  function automatic exp_t model(input int unsigned v);
    exp_t        e;
    int unsigned s;
    e.ovf = (v > 99999999);
    s = e.ovf ? 99999999 : v;
    e.number = '0;
    for (int d = 0; d < DIGITS; d++) begin
      e.number[d*4 +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input int unsigned v);
    int guard;
    guard = 0;
    value = BIN_WIDTH'(v);
    value_valid = 1'b1;
    while (!value_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!value_ready) begin
      cmp("send_timeout", 64'd0, 64'd1);
      value_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(v));
    @(negedge clock);
    value_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every update is checked against the scoreboard; otherwise number must hold.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      last_number = '0;
    end else if (updated) begin
      upd_count++;
      if (exp_q.size() == 0) begin
        cmp("unexpected_update", 64'(number), 64'(last_number));
      end else begin
        e = exp_q.pop_front();
        cmp("commit_number", 64'(number), 64'(e.number));
        cmp("commit_overflow", 64'(overflow), 64'(e.ovf));
      end
      last_number = number;
    end else begin
      cmp("number_stable", 64'(number), 64'(last_number));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    int n;
    int guard;
    int unsigned v;
    reset = 1'b1;
    value = '0;
    value_valid = 1'b0;
    frame_start = 1'b0;
    wait_cycles(3);
    cmp("reset_number", 64'(number), 64'd0);
    cmp("reset_updated", 64'(updated), 64'd0);
    cmp("reset_overflow", 64'(overflow), 64'd0);
    cmp("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    cmp("ready_after_reset", 64'(value_ready), 64'd1);

    // Basic conversion, commit 40 cycles later.
    u0 = upd_count;
    send(12345678);
    wait_cycles(39);
    pulse_frame();
    wait_cycles(2);
    cmp("basic_number", 64'(number), 64'h12345678);
    cmp("basic_overflow", 64'(overflow), 64'd0);
    cmp("basic_update_count", 64'(upd_count), 64'(u0 + 1));

    // Saturation at 10^8.
    send(100000000);
    wait_cycles(35);
    pulse_frame();
    wait_cycles(2);
    cmp("sat_number", 64'(number), 64'h99999999);
    cmp("sat_overflow", 64'(overflow), 64'd1);

    // Frame pulse during conversion is ignored; the later one commits.
    u0 = upd_count;
    send(42);
    wait_cycles(9);
    pulse_frame();
    wait_cycles(3);
    cmp("convert_frame_ignored", 64'(upd_count), 64'(u0));
    wait_cycles(46);
    pulse_frame();
    wait_cycles(2);
    cmp("late_frame_commit", 64'(upd_count), 64'(u0 + 1));
    cmp("late_number", 64'(number), 64'h00000042);
    cmp("late_overflow", 64'(overflow), 64'd0);

    // Value offered while pending is held off until after commit.
    send(555);
    wait_cycles(35);
    value = BIN_WIDTH'(7);
    value_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmp("pending_ready_low", 64'(value_ready), 64'd0);
      cmp("pending_busy", 64'(busy), 64'd1);
      @(negedge clock);
    end
    pulse_frame();
    cmp("pending_prior_value", 64'(number), 64'h00000555);
    send(7);
    wait_cycles(35);
    pulse_frame();
    wait_cycles(1);
    cmp("pending_next_value", 64'(number), 64'h00000007);

    // Reset mid-conversion discards the value.
    send(120000000);
    wait_cycles(4);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    cmp("midreset_number", 64'(number), 64'd0);
    cmp("midreset_busy", 64'(busy), 64'd0);
    cmp("midreset_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    cmp("midreset_ready", 64'(value_ready), 64'd1);
    u0 = upd_count;
    wait_cycles(30);
    pulse_frame();
    wait_cycles(10);
    cmp("midreset_no_update", 64'(upd_count), 64'(u0));

    // Latency with frame_start held high: busy spans handshake to commit.
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 0 : 99999999;
      send(v);
      frame_start = 1'b1;
      n = 0;
      guard = 0;
      while (!updated && guard < 100) begin
        if (busy) n++;
        @(negedge clock);
        guard++;
      end
      frame_start = 1'b0;
      cmp("latency_edges", 64'(n), 64'(BIN_WIDTH + 1));
      cmp("latency_number", 64'(number), (k == 0) ? 64'h0 : 64'h99999999);
    end

    // Randomised values with occasional ignored pulses during conversion.
    for (int r = 0; r < 30; r++) begin
      v = $urandom_range(0, (1 << BIN_WIDTH) - 1);
      send(v);
      if ($urandom_range(0, 1) == 1) begin
        wait_cycles($urandom_range(1, 20));
        pulse_frame();
      end
      wait_cycles(30 + $urandom_range(0, 5));
      pulse_frame();
    end
    wait_cycles(5);
    cmp("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
